// File: rtl/xbar_peri_nslave.sv
`default_nettype none
// ============================================================================
//  Module      : xbar_peri_nslave
//  Description : 1-master / N-slave TileLink-UL crossbar for the peripheral
//                clock domain. Channel A is routed by address decode.
//                Unmapped requests go to a one-entry error responder.
//                Channel D from the slaves and the error responder is merged
//                by a round-robin arbiter that holds its grant while the
//                master stalls. A global outstanding counter throttles A.
//  Ports       : clk/reset             clock, async active-high reset
//                a_* / d_*             master-side A request, D response
//                a_*_out / a_ready_out A request to slaves (payload broadcast)
//                d_*_in / d_ready_in   packed per-slave D responses
//  Revision    : 1.0 - initial release
// ============================================================================
module xbar_peri_nslave #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SIZE_WIDTH      = 3,
    parameter int OPCODE_WIDTH    = 3,
    parameter int PARAM_WIDTH     = 3,
    parameter int SOURCE_WIDTH    = 1,
    parameter int SINK_WIDTH      = 1,
    parameter int NUM_SLAVES      = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int MAX_OUTSTANDING = 4,
    localparam int MASK_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    // master channel A
    input  logic                                 a_valid,
    output logic                                 a_ready,
    input  logic [OPCODE_WIDTH-1:0]              a_opcode,
    input  logic [PARAM_WIDTH-1:0]               a_param,
    input  logic [SIZE_WIDTH-1:0]                a_size,
    input  logic [SOURCE_WIDTH-1:0]              a_source,
    input  logic [ADDR_WIDTH-1:0]                a_address,
    input  logic [MASK_WIDTH-1:0]                a_mask,
    input  logic [DATA_WIDTH-1:0]                a_data,
    // master channel D
    output logic                                 d_valid,
    input  logic                                 d_ready,
    output logic [OPCODE_WIDTH-1:0]              d_opcode,
    output logic [PARAM_WIDTH-1:0]               d_param,
    output logic [SIZE_WIDTH-1:0]                d_size,
    output logic [SOURCE_WIDTH-1:0]              d_source,
    output logic [SINK_WIDTH-1:0]                d_sink,
    output logic [DATA_WIDTH-1:0]                d_data,
    output logic                                 d_error,
    // slave channel A
    output logic [NUM_SLAVES-1:0]                a_valid_out,
    input  logic [NUM_SLAVES-1:0]                a_ready_out,
    output logic [OPCODE_WIDTH-1:0]              a_opcode_out,
    output logic [PARAM_WIDTH-1:0]               a_param_out,
    output logic [SIZE_WIDTH-1:0]                a_size_out,
    output logic [SOURCE_WIDTH-1:0]              a_source_out,
    output logic [ADDR_WIDTH-1:0]                a_address_out,
    output logic [MASK_WIDTH-1:0]                a_mask_out,
    output logic [DATA_WIDTH-1:0]                a_data_out,
    // slave channel D
    input  logic [NUM_SLAVES-1:0]                d_valid_in,
    output logic [NUM_SLAVES-1:0]                d_ready_in,
    input  logic [NUM_SLAVES*OPCODE_WIDTH-1:0]   d_opcode_in,
    input  logic [NUM_SLAVES*PARAM_WIDTH-1:0]    d_param_in,
    input  logic [NUM_SLAVES*SIZE_WIDTH-1:0]     d_size_in,
    input  logic [NUM_SLAVES*SOURCE_WIDTH-1:0]   d_source_in,
    input  logic [NUM_SLAVES*SINK_WIDTH-1:0]     d_sink_in,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]     d_data_in,
    input  logic [NUM_SLAVES-1:0]                d_error_in
);

    localparam int c_NREQ  = NUM_SLAVES + 1;          // slaves + error responder
    localparam int c_IDX_W = $clog2(NUM_SLAVES + 1);
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_ACK      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_ACK_DATA = OPCODE_WIDTH'(1);
    localparam logic [c_IDX_W-1:0]      c_ERR_IDX     = c_IDX_W'(NUM_SLAVES);

    logic [c_CNT_W-1:0]      r_count;
    logic                    r_err_valid;
    logic [OPCODE_WIDTH-1:0] r_err_opcode;
    logic [SIZE_WIDTH-1:0]   r_err_size;
    logic [SOURCE_WIDTH-1:0] r_err_source;
    logic [c_IDX_W-1:0]      r_ptr;      // last granted requester
    logic                    r_locked;   // r_ptr must be re-granted

    logic [NUM_SLAVES-1:0]   w_route;
    logic                    w_mapped;
    logic                    w_sel_ready;
    logic                    w_full;
    logic                    w_a_fire;
    logic                    w_d_fire;
    logic [c_NREQ-1:0]       w_req;
    logic [c_IDX_W-1:0]      w_gnt;
    logic                    w_gnt_valid;

    // Address decode; iterating downwards lets the lowest index win overlaps.
    always_comb begin
        w_route     = '0;
        w_mapped    = 1'b0;
        w_sel_ready = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((a_address & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_route     = '0;
                w_route[i]  = 1'b1;
                w_mapped    = 1'b1;
                w_sel_ready = a_ready_out[i];
            end
        end
    end

    assign w_full      = (r_count == c_CNT_W'(MAX_OUTSTANDING));
    assign a_valid_out = (a_valid && !w_full && !reset) ? w_route : '0;
    assign a_ready     = !reset && !w_full && (w_mapped ? w_sel_ready : !r_err_valid);
    assign w_a_fire    = a_valid && a_ready;

    assign a_opcode_out  = a_opcode;
    assign a_param_out   = a_param;
    assign a_size_out    = a_size;
    assign a_source_out  = a_source;
    assign a_address_out = a_address;
    assign a_mask_out    = a_mask;
    assign a_data_out    = a_data;

    assign w_req = {r_err_valid, d_valid_in};

    // Round-robin grant: a stalled grant is held; otherwise scan from the
    // requester after the last granted one. Descending k keeps the nearest.
    always_comb begin : p_arb
        int idx;
        idx         = 0;
        w_gnt       = r_ptr;
        w_gnt_valid = 1'b0;
        if (r_locked && w_req[r_ptr]) begin
            w_gnt_valid = 1'b1;
        end else begin
            for (int k = c_NREQ; k >= 1; k--) begin
                idx = int'(r_ptr) + k;
                if (idx >= c_NREQ) idx = idx - c_NREQ;
                if (w_req[idx]) begin
                    w_gnt       = c_IDX_W'(idx);
                    w_gnt_valid = 1'b1;
                end
            end
        end
    end

    assign d_valid  = w_gnt_valid && !reset;
    assign w_d_fire = d_valid && d_ready;

    // D payload mux; the error responder is the default source.
    always_comb begin
        d_opcode = r_err_opcode;
        d_param  = '0;
        d_size   = r_err_size;
        d_source = r_err_source;
        d_sink   = '0;
        d_data   = '0;
        d_error  = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_gnt == c_IDX_W'(i)) begin
                d_opcode = d_opcode_in[i*OPCODE_WIDTH +: OPCODE_WIDTH];
                d_param  = d_param_in[i*PARAM_WIDTH +: PARAM_WIDTH];
                d_size   = d_size_in[i*SIZE_WIDTH +: SIZE_WIDTH];
                d_source = d_source_in[i*SOURCE_WIDTH +: SOURCE_WIDTH];
                d_sink   = d_sink_in[i*SINK_WIDTH +: SINK_WIDTH];
                d_data   = d_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                d_error  = d_error_in[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dready
            assign d_ready_in[gi] = d_valid && d_ready && (w_gnt == c_IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_err_valid  <= 1'b0;
            r_err_opcode <= '0;
            r_err_size   <= '0;
            r_err_source <= '0;
            r_ptr        <= '0;
            r_locked     <= 1'b0;
        end else begin
            // A D response with nothing outstanding is forwarded but not counted.
            if (w_a_fire && !w_d_fire) begin
                r_count <= r_count + 1'b1;
            end else if (w_d_fire && !w_a_fire && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end

            // Capture and release cannot coincide: a_ready needs an empty buffer.
            if (w_a_fire && !w_mapped) begin
                r_err_valid  <= 1'b1;
                r_err_opcode <= (a_opcode == c_OP_GET) ? c_OP_ACK_DATA : c_OP_ACK;
                r_err_size   <= a_size;
                r_err_source <= a_source;
            end else if (w_d_fire && (w_gnt == c_ERR_IDX)) begin
                r_err_valid <= 1'b0;
            end

            if (d_valid) begin
                r_ptr    <= w_gnt;
                r_locked <= !d_ready;
            end else begin
                r_locked <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/xbar_peri_nslave.md
# xbar_peri_nslave

Parametrised 1-master/N-slave TileLink-UL crossbar for the 24 MHz peripheral domain, between the CDC adapter (master side) and the peripheral slaves. Channel A requests are routed by address decode to one slave, and unmapped addresses are answered by an internal error responder. Channel D responses from all slaves and the error responder are merged through a locked round-robin arbiter. A global outstanding-transaction limit throttles Channel A.

## Interface
Parameters
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; MASK_WIDTH = DATA_WIDTH/8
- SIZE_WIDTH, 3; OPCODE_WIDTH, 3; PARAM_WIDTH, 3
- SOURCE_WIDTH, 1, source ID width
- NUM_SLAVES, 2, number of slave ports (1..8)
- SLAVE_BASE, {32'h1000_0000, 32'h0000_0000}, packed NUM_SLAVES×ADDR_WIDTH; slice i is the base of slave i
- SLAVE_MASK, {32'hFFFF_0000, 32'hFFFF_0000}, packed; slice i is the decode mask of slave i
- MAX_OUTSTANDING, 4, maximum in-flight requests (≥1)

Ports
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- a_valid/a_ready  in/out  1  master A handshake
- a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data  in  field widths  master A payload
- d_valid/d_ready  out/in  1  master D handshake
- d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error  out  field widths  master D payload
- a_valid_out  out  NUM_SLAVES  per-slave A valid
- a_ready_out  in  NUM_SLAVES  per-slave A ready
- a_*_out  out  field widths  A payload broadcast to all slaves
- d_valid_in  in  NUM_SLAVES  per-slave D valid
- d_ready_in  out  NUM_SLAVES  per-slave D ready
- d_opcode_in, d_param_in, d_size_in, d_source_in, d_sink_in, d_data_in, d_error_in  in  NUM_SLAVES×field width, packed  per-slave D payload

## Operation
- **Decode:** hit[i] = ((a_address & SLAVE_MASK[i]) == SLAVE_BASE[i]). The lowest index wins on overlap. No hit means unmapped.
- **A routing (combinational):** a_valid_out[sel] = a_valid && !full. a_ready = a_ready_out[sel] && !full. The payload is passed unchanged.
- **Unmapped A:** a_ready = !full && err_empty. On fire, the error buffer captures source, size and opcode.
- **Error responder:** one-entry buffer that presents a D response at requester index NUM_SLAVES.
  - d_opcode = 1 (AccessAckData) for Get (4), otherwise 0 (AccessAck).
  - d_error = 1, d_data = 0, d_param = 0, d_sink = 0; d_size and d_source are echoed.
  - The buffer empties when its response fires.
- **Outstanding counter:** width clog2(MAX_OUTSTANDING+1).
  - +1 on master A fire; −1 on master D fire; unchanged if both occur in the same cycle.
  - full = (count == MAX_OUTSTANDING).
- **D arbiter:** round-robin over NUM_SLAVES+1 requesters.
  - Search starts at the index after the last granted one.
  - A grant is locked while the granted requester's valid is high and d_ready is low. The lock releases on fire.
  - d_ready_in[g] = d_ready for the granted slave; 0 for all others. The D payload is muxed from the granted requester.
- A D response that arrives while count == 0 is still forwarded; the counter saturates at 0 and does not underflow.

## Timing
- A path: zero latency, combinational.
- Error response: d_valid rises the cycle after unmapped A acceptance, at the earliest. It may be later if another response holds the D lock.
- D path: combinational mux. Grant and lock state are registered, so the arbitration decision is based on the previous cycle's pointer.
- Reset (asynchronous, immediate): count = 0, error buffer empty, rr pointer = 0, lock cleared.
  - Result: d_valid = 0, all a_valid_out = 0, all d_ready_in = 0, a_ready = 0 until reset deasserts.
  - Reset mid-transaction drops all in-flight state. No response is replayed.
- With full asserted, a_ready = 0. A request accepted on the same cycle as a D fire at count == MAX is impossible, because a_ready was already 0 that cycle.

## Test plan
- **Mapped Get:** Get to 0x1000_0010 with NUM_SLAVES=2 → a_valid_out = 2'b10. Slave 1 returns data 0xCAFE_F00D → master sees d_opcode=1, d_data=0xCAFEF00D, d_error=0. Count returns to 0.
- **Unmapped access:** PutFullData to 0x2000_0000 → no a_valid_out. One cycle later d_valid=1, d_opcode=0, d_error=1, source echoed. Repeat with a Get → d_opcode=1, d_data=0.
- **Outstanding limit:** MAX_OUTSTANDING=4, 4 Gets accepted with d_ready=0 → a_ready=0 on the 5th. One D fire → the 5th request is accepted the next cycle.
- **Arbitration fairness:** slaves 0 and 1 both hold d_valid continuously, with d_ready=1 → grants alternate 0,1,0,1.
  - With d_ready=0 for 3 cycles, the grant stays locked and the payload stays stable.
- **Simultaneous events:** A fire and D fire in the same cycle → count unchanged. Unmapped A arriving while the error buffer is full → a_ready=0 until the error response fires.
- **Reset mid-operation:** assert reset with 2 outstanding requests and the error buffer full → d_valid=0 and count=0 immediately. After release, a fresh Get completes normally.
